// File: rtl/config_pkg.sv
// Shared constants and types for the UART ALU datapath.
// Response framing mirrors the request format parsed on the receive side.
package config_pkg;

    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;

    localparam int unsigned HDR_BYTES = 4;
    localparam logic [7:0]  RSV_BYTE  = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StHdrOp,
        StHdrRsv,
        StHdrLsb,
        StHdrMsb,
        StPayload
    } tx_state_t;

endpackage

// File: rtl/piso_8.sv
// Parallel-load, serial-out byte shift register; byte_o is the low byte.
// Transmit counterpart of shift_8.
module piso_8 #(
    parameter int unsigned RESULT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [RESULT_W-1:0] data_i,
    output logic [7:0]          byte_o
);

    logic [RESULT_W-1:0] shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= data_i;
        end else if (shift_i) begin
            shift_q <= shift_q >> 8;
        end
    end

    assign byte_o = shift_q[7:0];

endmodule

// File: rtl/resp_packetizer.sv
// Frames one result word as opcode, reserved, length LSB/MSB, payload (LSB first)
// onto the byte stream feeding the UART transmitter.
module resp_packetizer
    import config_pkg::*;
#(
    parameter int unsigned RESULT_W  = 64,
    parameter int unsigned MAX_BYTES = RESULT_W / 8,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          opcode_i,
    input  logic [RESULT_W-1:0] result_i,
    input  logic [CNT_W-1:0]    nbytes_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [7:0]          data_o,
    output logic                valid_o,
    input  logic                ready_i
);

    tx_state_t        state_q, state_d;
    logic [7:0]       op_q;
    logic [15:0]      len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] n_eff;
    logic [15:0]      len_d;
    logic [7:0]       payload_byte;
    logic             accept;
    logic             xfer;

    // Oversized requests are silently clamped to the word width.
    always_comb begin
        n_eff = (nbytes_i > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes_i;
        len_d = 16'(HDR_BYTES) + 16'(n_eff);
    end

    assign ready_o = (state_q == StIdle);
    assign valid_o = ~ready_o;
    assign accept  = valid_i && ready_o;
    assign xfer    = valid_o && ready_i;

    piso_8 #(
        .RESULT_W(RESULT_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .shift_i(xfer && (state_q == StPayload)),
        .data_i (result_i),
        .byte_o (payload_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= opcode_i;
                len_q <= len_d;
                cnt_q <= n_eff;
            end else if (xfer && (state_q == StPayload)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_o  = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StHdrOp;
            end
            StHdrOp: begin
                data_o = op_q;
                if (xfer) state_d = StHdrRsv;
            end
            StHdrRsv: begin
                data_o = RSV_BYTE;
                if (xfer) state_d = StHdrLsb;
            end
            StHdrLsb: begin
                data_o = len_q[7:0];
                if (xfer) state_d = StHdrMsb;
            end
            StHdrMsb: begin
                data_o = len_q[15:8];
                if (xfer) state_d = (cnt_q != '0) ? StPayload : StIdle;
            end
            StPayload: begin
                data_o = payload_byte;
                if (xfer && (cnt_q == CNT_W'(1))) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_resp_packetizer.sv
// Directed bench for resp_packetizer: framing, backpressure, zero/clamped length,
// asynchronous reset mid-packet, busy-ignore and back-to-back spacing.
module tb_resp_packetizer;
    import config_pkg::*;

    localparam int unsigned RESULT_W  = 64;
    localparam int unsigned CNT_W     = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          opcode_i;
    logic [RESULT_W-1:0] result_i;
    logic [CNT_W-1:0]    nbytes_i;
    logic                valid_i;
    logic                ready_o;
    logic [7:0]          data_o;
    logic                valid_o;
    logic                ready_i;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] expq[$];

    resp_packetizer #(
        .RESULT_W(RESULT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode_i(opcode_i),
        .result_i(result_i),
        .nbytes_i(nbytes_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one result at a negedge; returns at the next negedge (first header byte).
    task automatic send(input logic [7:0] op, input logic [63:0] res, input logic [3:0] nb);
        @(negedge clk);
        opcode_i = op;
        result_i = res;
        nbytes_i = nb;
        valid_i  = 1'b1;
        chk("accept_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Collect nexp bytes from expq; bp selects a 1,0,0,1,... ready pattern.
    task automatic drain(input int nexp, input bit bp, input bit check_end);
        logic [15:0] pat;
        logic [7:0]  held;
        bit          held_v;
        bit          r;
        int          idx;
        int          cyc;
        pat    = 16'b1001_0110_1100_1010;
        held   = 8'h00;
        held_v = 1'b0;
        idx    = 0;
        cyc    = 0;
        while (idx < nexp && cyc < 200) begin
            r = bp ? pat[15 - (cyc % 16)] : 1'b1;
            ready_i = r;
            chk("valid_hold", 64'(valid_o), 64'd1);
            if (held_v) chk("stall_stable", 64'(data_o), 64'(held));
            if (r) begin
                chk($sformatf("byte%0d", idx), 64'(data_o), 64'(expq[idx]));
                idx++;
                held_v = 1'b0;
            end else begin
                held   = data_o;
                held_v = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        chk("drain_timeout", 64'(idx), 64'(nexp));
        ready_i = 1'b1;
        if (check_end) begin
            chk("end_valid", 64'(valid_o), 64'd0);
            chk("end_ready", 64'(ready_o), 64'd1);
        end
    endtask

    initial begin
        bit b2b_pat [11];
        b2b_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst      = 1'b1;
        opcode_i = '0;
        result_i = '0;
        nbytes_i = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data",  64'(data_o),  64'd0);

        // ADD, 4-byte payload, no backpressure
        send(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
        expq = '{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        drain(8, 1'b0, 1'b1);

        // MUL, full 8-byte payload
        send(OP_MUL, 64'h0102_0304_0506_0708, 4'd8);
        expq = '{OP_MUL, 8'h00, 8'h0C, 8'h00,
                 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        drain(12, 1'b0, 1'b1);

        // ADD again under backpressure
        send(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
        expq = '{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        drain(8, 1'b1, 1'b1);

        // Zero payload: header only
        send(OP_ECHO, 64'hDEAD_BEEF_CAFE_F00D, 4'd0);
        expq = '{OP_ECHO, 8'h00, 8'h04, 8'h00};
        drain(4, 1'b0, 1'b1);

        // Oversized count clamps to 8 payload bytes
        send(OP_DIV, 64'hA8A7_A6A5_A4A3_A2A1, 4'd9);
        expq = '{OP_DIV, 8'h00, 8'h0C, 8'h00,
                 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        drain(12, 1'b0, 1'b1);

        // Asynchronous reset after the 2nd payload byte
        send(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
        expq = '{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56};
        drain(6, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(valid_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd1);
        chk("arst_data",  64'(data_o),  64'd0);
        #3 rst = 1'b0;
        send(OP_MUL, 64'h0102_0304_0506_0708, 4'd8);
        expq = '{OP_MUL, 8'h00, 8'h0C, 8'h00,
                 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        drain(12, 1'b0, 1'b1);

        // valid_i pulsed with different data while busy is ignored
        send(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
        expq = '{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h78};
        drain(5, 1'b0, 1'b0);
        opcode_i = OP_DIV;
        result_i = 64'hFFFF_FFFF_FFFF_FFFF;
        nbytes_i = 4'd8;
        valid_i  = 1'b1;
        ready_i  = 1'b0;
        chk("busy_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        expq = '{8'h56, 8'h34, 8'h12};
        drain(3, 1'b0, 1'b1);

        // Back-to-back: valid_i held, one idle cycle between packets
        opcode_i = OP_ECHO;
        result_i = 64'h0;
        nbytes_i = 4'd0;
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("b2b_valid%0d", c), 64'(valid_o), 64'(b2b_pat[c]));
            if (c == 1 || c == 6) chk("b2b_op", 64'(data_o), 64'(OP_ECHO));
            if (c == 3 || c == 8) chk("b2b_len", 64'(data_o), 64'h04);
            if (c == 10) valid_i = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_ready", 64'(ready_o), 64'd1);
        chk("b2b_end_valid", 64'(valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/resp_packetizer.md
Name: resp_packetizer

Overview:
- Transmit-side framer for the UART ALU. It takes one completed result word (ALU output or echo data) plus its opcode and payload byte count.
- It serialises them as a response packet onto the byte stream that feeds the UART transmitter.
- The frame format is identical to the request format parsed on the receive side: opcode, reserved, length LSB, length MSB, then the payload, least-significant byte first.
- Length counts all bytes, including the 4 header bytes.

Parameters:
- RESULT_W, 64, width of the result word in bits; must be a multiple of 8.
- MAX_BYTES, RESULT_W/8, largest payload in bytes.
- CNT_W, $clog2(MAX_BYTES+1), width of the payload byte-count field.

Ports:
- clk  input  1  system clock; one clock domain, all logic on posedge clk.
- rst  input  1  reset; asynchronous, active-high.
- opcode_i  input  8  opcode to return in the header (ECHO/ADD/MUL/DIV from config_pkg).
- result_i  input  RESULT_W  payload word; byte 0 = result_i[7:0].
- nbytes_i  input  CNT_W  number of payload bytes, 0..MAX_BYTES.
- valid_i  input  1  upstream offers a result.
- ready_o  output  1  block can accept a result.
- data_o  output  8  byte to the UART TX.
- valid_o  output  1  data_o is valid.
- ready_i  input  1  UART TX accepts the byte.

Behaviour:
- Reset (asynchronous, any time, including mid-packet):
  - state goes to IDLE and the packet in flight is abandoned; no partial bytes resume.
  - ready_o=1, valid_o=0, data_o=0.
  - internal opcode, length, shift and count registers go to 0.
- Upstream accept:
  - A result is accepted on a cycle with valid_i && ready_o.
  - ready_o=1 only in IDLE.
  - On accept, register opcode_i, result_i and the effective count n = min(nbytes_i, MAX_BYTES).
  - nbytes_i > MAX_BYTES is clamped to MAX_BYTES; no error is flagged.
- Downstream transfer:
  - A byte is transferred on a cycle with valid_o && ready_i.
  - While valid_o=1 and ready_i=0, data_o and valid_o hold stable.
  - valid_o never drops without a transfer, except on reset.
- States (tx_state_t): IDLE, HDR_OP, HDR_RSV, HDR_LSB, HDR_MSB, PAYLOAD.
  - IDLE: valid_o=0. On accept go to HDR_OP.
  - HDR_OP: data_o = registered opcode. On transfer go to HDR_RSV.
  - HDR_RSV: data_o = 8'h00. On transfer go to HDR_LSB.
  - HDR_LSB: data_o = len[7:0], where len = 16'(4 + n). On transfer go to HDR_MSB.
  - HDR_MSB: data_o = len[15:8]. On transfer go to PAYLOAD if n != 0, otherwise to IDLE.
  - PAYLOAD: data_o = shift_reg[7:0]. Each transfer shifts the register right by 8 and decrements the remaining count. The transfer of the last byte (remaining == 1) goes to IDLE.
- valid_o = (state != IDLE). data_o is driven from registers only, so there is no combinational path from ready_i to data_o.
- Latency and throughput:
  - First byte (valid_o=1) appears the cycle after accept.
  - With ready_i held high, a packet takes exactly 4+n consecutive cycles.
  - ready_o rises the cycle after the final transfer, so back-to-back packets have exactly one idle cycle between them.
- valid_i while busy is ignored; upstream must hold its data until ready_o.
- A simultaneous accept and transfer is impossible, since ready_o and valid_o are mutually exclusive.

Decomposition:
- config_pkg additions:
  - tx_state_t enum.
  - HDR_BYTES = 4.
  - RSV_BYTE = 8'h00.
  - Reuse the existing ECHO/ADD/MUL/DIV opcode constants.
- One natural sub-module, piso_8: a parallel-load, serial-out byte shift register with load_i, shift_i, data_i[RESULT_W-1:0] and byte_o[7:0]. It is the transmit counterpart of shift_8.
- FSM, length computation and remaining-count counter stay in resp_packetizer.

Test Plan:
- ADD result: opcode=ADD, result_i=64'h0000_0000_1234_5678, nbytes=4, ready_i=1 -> bytes ADD,00,08,00,78,56,34,12 on 8 consecutive cycles; ready_o high again on the 9th cycle.
- MUL result: nbytes=8, result_i=64'h0102_0304_0506_0708 -> ADD replaced by MUL, length bytes 0C,00, payload 08,07,06,05,04,03,02,01.
- Backpressure: ready_i toggles 1,0,0,1,… randomly during the ADD packet -> identical byte sequence; data_o stable through every stall cycle; no byte duplicated or dropped.
- Zero payload and clamping:
  - nbytes=0 -> 4 bytes only (op,00,04,00), then IDLE.
  - nbytes=9 with RESULT_W=64 -> length 0C,00 and exactly 8 payload bytes.
- Reset mid-packet: assert rst asynchronously (not clock-aligned) after the 2nd payload byte -> valid_o=0, ready_o=1 immediately. The next accepted packet starts cleanly from its opcode byte.
- Busy ignore and back-to-back: pulse valid_i with a different result during PAYLOAD -> ignored. Holding valid_i continuously -> packets separated by exactly one cycle with valid_o=0.
